// File: rtl/bsg_source_sync_downstream_token.sv
// bsg_source_sync_downstream_token
//
// Receive end of a source-synchronous link. Pad-side valid/data are captured
// into input flops and buffered in a credit-sized FIFO for the core. Every
// 2^lg_credit_to_token_decimation_p core dequeues toggle the outgoing token
// line. While the link is held in reset the block drives the 0->1->0
// token-reset pulse that the transmitter expects.
//
// Optional feature macro: BSG_SOURCE_SYNC_DOWNSTREAM_OVERFLOW_CHECK_EN
//   defined   : overflow_r_o is a sticky flag for dropped beats, and
//               simulation reports each drop with $error.
//   undefined : overflow_r_o tied to 0. Beats are still dropped when full.
//
// Ports
//   io_clk_i       single clock for capture, FIFO, core side and token
//   reset_i        synchronous, active-high
//   link_enable_i  0 holds the link in reset and flushes the FIFO
//   io_data_i      pad data
//   io_valid_i     pad valid
//   core_data_o    FIFO head
//   core_valid_o   FIFO non-empty and link running
//   core_yumi_i    dequeue, only legal while core_valid_o=1
//   io_token_r_o   registered token line to pad
//   overflow_r_o   sticky: a beat arrived while the FIFO was full
module bsg_source_sync_downstream_token #(
    parameter int channel_width_p                 = 16,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = 3,
    parameter int token_reset_hold_p              = 4
) (
    input  logic                       io_clk_i,
    input  logic                       reset_i,
    input  logic                       link_enable_i,
    input  logic [channel_width_p-1:0] io_data_i,
    input  logic                       io_valid_i,
    output logic [channel_width_p-1:0] core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_yumi_i,
    output logic                       io_token_r_o,
    output logic                       overflow_r_o
);

    localparam int HOLD_W = (token_reset_hold_p > 1) ? $clog2(token_reset_hold_p) : 1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_TOK_LO,
        ST_TOK_HI,
        ST_TOK_WAIT,
        ST_RUN
    } state_e;

    typedef logic [lg_fifo_depth_p:0]                 ptr_t;
    typedef logic [HOLD_W-1:0]                        hold_t;
    typedef logic [lg_credit_to_token_decimation_p-1:0] tok_cnt_t;

    localparam hold_t HOLD_LAST = hold_t'(token_reset_hold_p - 1);

    state_e                     state;
    hold_t                      hold_cnt;
    logic                       token_r;
    tok_cnt_t                   tok_cnt;

    logic                       io_valid_r;
    logic [channel_width_p-1:0] io_data_r;

    logic [channel_width_p-1:0] mem [2**lg_fifo_depth_p];
    ptr_t                       wr_ptr, rd_ptr;

    logic running, empty, full, enq, deq, tok_wrap;

    assign running  = (state == ST_RUN);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[lg_fifo_depth_p] != rd_ptr[lg_fifo_depth_p]) &&
                      (wr_ptr[lg_fifo_depth_p-1:0] == rd_ptr[lg_fifo_depth_p-1:0]);
    // Illegal yumi (nothing valid) is masked so pointers and counter hold.
    assign deq      = core_yumi_i && core_valid_o;
    // A dequeue in the same cycle frees the slot, so a full FIFO still accepts.
    assign enq      = io_valid_r && running && (!full || deq);
    assign tok_wrap = deq && (tok_cnt == '1);

    assign core_valid_o = running && !empty;
    assign core_data_o  = mem[rd_ptr[lg_fifo_depth_p-1:0]];
    assign io_token_r_o = token_r;

    // Link FSM; also owns the registered token line.
    always_ff @(posedge io_clk_i) begin
        if (reset_i) begin
            state    <= ST_RESET;
            hold_cnt <= '0;
            token_r  <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state    <= ST_TOK_LO;
                    hold_cnt <= '0;
                    token_r  <= 1'b0;
                end
                ST_TOK_LO: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_TOK_HI;
                        hold_cnt <= '0;
                        token_r  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + hold_t'(1);
                    end
                end
                ST_TOK_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_TOK_WAIT;
                        hold_cnt <= '0;
                        token_r  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + hold_t'(1);
                    end
                end
                ST_TOK_WAIT: begin
                    token_r <= 1'b0;
                    if (link_enable_i)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!link_enable_i) begin
                        state    <= ST_TOK_LO;
                        hold_cnt <= '0;
                        token_r  <= 1'b0;
                    end else if (tok_wrap) begin
                        token_r <= ~token_r;
                    end
                end
                default: begin
                    state    <= ST_RESET;
                    hold_cnt <= '0;
                    token_r  <= 1'b0;
                end
            endcase
        end
    end

    // Pad capture flops, held at zero unless the link is running.
    always_ff @(posedge io_clk_i) begin
        if (reset_i || !running) begin
            io_valid_r <= 1'b0;
            io_data_r  <= '0;
        end else begin
            io_valid_r <= io_valid_i;
            io_data_r  <= io_data_i;
        end
    end

    // Pointers and token counter stay cleared whenever the link is not running,
    // which implements the flush on link disable.
    always_ff @(posedge io_clk_i) begin
        if (reset_i || !running) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tok_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_t'(1);
            if (deq) begin
                rd_ptr  <= rd_ptr + ptr_t'(1);
                tok_cnt <= tok_cnt + tok_cnt_t'(1);
            end
        end
    end

    // Storage only; entries are meaningless until written, so no reset.
    always_ff @(posedge io_clk_i) begin
        if (enq)
            mem[wr_ptr[lg_fifo_depth_p-1:0]] <= io_data_r;
    end

`ifdef BSG_SOURCE_SYNC_DOWNSTREAM_OVERFLOW_CHECK_EN
    logic drop, overflow_r;
    assign drop = io_valid_r && running && full && !deq;

    always_ff @(posedge io_clk_i) begin
        if (reset_i || !running)
            overflow_r <= 1'b0;
        else if (drop)
            overflow_r <= 1'b1;
    end

    assign overflow_r_o = overflow_r;

`ifndef SYNTHESIS
    always_ff @(posedge io_clk_i) begin
        if (!reset_i && drop)
            $error("bsg_source_sync_downstream_token: beat dropped, FIFO full");
    end
`endif
`else
    assign overflow_r_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_source_sync_downstream_token.sv
module tb_bsg_source_sync_downstream_token;

`ifdef BSG_SOURCE_SYNC_DOWNSTREAM_OVERFLOW_CHECK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, link_en, io_valid, yumi;
    logic [15:0] io_data;
    logic [15:0] core_data;
    logic        core_valid, token, overflow;

    int tests = 0;
    int fails = 0;
    int deq_total = 0;

    bsg_source_sync_downstream_token #(
        .channel_width_p(16),
        .lg_fifo_depth_p(6),
        .lg_credit_to_token_decimation_p(3),
        .token_reset_hold_p(4)
    ) dut (
        .io_clk_i     (clk),
        .reset_i      (reset),
        .link_enable_i(link_en),
        .io_data_i    (io_data),
        .io_valid_i   (io_valid),
        .core_data_o  (core_data),
        .core_valid_o (core_valid),
        .core_yumi_i  (yumi),
        .io_token_r_o (token),
        .overflow_r_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the cycle in which the link was put into reset.
    // Token must be low 4 cycles, high 4 cycles, then low.
    task automatic check_pulse(input string tag, input bit enable_early);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (enable_early && i == 2) link_en = 1'b1;
            check($sformatf("%s_tok%0d", tag, i), {31'b0, token}, {31'b0, (i >= 5 && i <= 8)});
            check($sformatf("%s_cv%0d", tag, i), {31'b0, core_valid}, 32'd0);
        end
    endtask

    task automatic send(input logic [15:0] d);
        io_valid = 1'b1;
        io_data  = d;
        tick();
        io_valid = 1'b0;
        io_data  = 16'hBEEF;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_d;
        reset = 1'b1; link_en = 1'b0; io_valid = 1'b0; io_data = '0; yumi = 1'b0;
        repeat (3) tick();
        check("rst_cv",  {31'b0, core_valid}, 32'd0);
        check("rst_tok", {31'b0, token},      32'd0);
        check("rst_ovf", {31'b0, overflow},   32'd0);

        // Reset release with the link still disabled.
        reset = 1'b0;
        check_pulse("rstpulse", 1'b0);

        link_en = 1'b1;
        tick();

        // Latency: beat at N visible at N+2; junk data with valid low not stored.
        send(16'h1234);
        check("lat_n1_cv", {31'b0, core_valid}, 32'd0);
        tick();
        check("lat_n2_cv", {31'b0, core_valid}, 32'd1);
        check("lat_n2_d",  {16'b0, core_data},  32'h1234);
        tick();
        yumi = 1'b1; tick(); yumi = 1'b0; deq_total++;
        check("lat_empty", {31'b0, core_valid}, 32'd0);
        // Illegal yumi on empty FIFO: no counter change.
        yumi = 1'b1; tick(); yumi = 1'b0;
        check("illegal_cv", {31'b0, core_valid}, 32'd0);

        // Fill all 64 entries.
        for (int i = 0; i < 64; i++) send(16'(16'h0100 + i));
        tick(); tick();
        check("full_cv",   {31'b0, core_valid}, 32'd1);
        check("full_head", {16'b0, core_data},  32'h0100);

        // Full FIFO, beat arrives the same cycle as yumi: accepted, no drop.
        send(16'h0200);
        yumi = 1'b1; tick(); yumi = 1'b0; deq_total++;
        check("simul_ovf",  {31'b0, overflow},  32'd0);
        check("simul_head", {16'b0, core_data}, 32'h0101);

        // 65th beat with no yumi is dropped.
        send(16'hDEAD);
        tick();
        check("ovf_flag", {31'b0, overflow},  {31'b0, OVF_EN});
        check("ovf_head", {16'b0, core_data}, 32'h0101);

        // Drain everything at full rate; token toggles every 8 dequeues.
        yumi = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_d = (i < 63) ? 16'(16'h0101 + i) : 16'h0200;
            check($sformatf("drain_cv%0d", i), {31'b0, core_valid}, 32'd1);
            check($sformatf("drain_d%0d", i),  {16'b0, core_data},  {16'b0, exp_d});
            tick();
            deq_total++;
            check($sformatf("drain_tok%0d", i), {31'b0, token}, 32'((deq_total / 8) % 2));
        end
        yumi = 1'b0;
        check("drain_empty", {31'b0, core_valid}, 32'd0);
        check("drain_ovf",   {31'b0, overflow},   {31'b0, OVF_EN});

        // Link disabled mid-stream with 10 beats buffered.
        for (int i = 0; i < 10; i++) send(16'(16'h0300 + i));
        tick(); tick();
        check("ld_cv",   {31'b0, core_valid}, 32'd1);
        check("ld_head", {16'b0, core_data},  32'h0300);
        link_en = 1'b0;
        check_pulse("ldpulse", 1'b1);
        deq_total = 0;
        check("ld_ovf",      {31'b0, overflow},   32'd0);
        check("reen_empty",  {31'b0, core_valid}, 32'd0);

        // Token counter was cleared: toggle after exactly 8 dequeues.
        for (int i = 0; i < 8; i++) send(16'(16'h0400 + i));
        tick(); tick();
        yumi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("re_d%0d", i), {16'b0, core_data}, 32'(16'h0400 + i));
            tick();
            deq_total++;
            check($sformatf("re_tok%0d", i), {31'b0, token}, 32'((deq_total / 8) % 2));
        end
        yumi = 1'b0;
        check("re_empty", {31'b0, core_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
